// File: rtl/instr_fetch_responder_pkg.sv
// Shared types and helpers for the instruction fetch responder.
// Holds the NOP word, the response bundle and the address fault check.
package rv_fetch_pkg;

    localparam int FETCH_WIDTH = 32;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [31:0]            instr;
        logic [FETCH_WIDTH-1:0] addr;
        logic                   fault;
    } fetch_resp_t;

    // Misaligned, or beyond the word-indexed memory.
    function automatic logic addr_fault(
        input logic [FETCH_WIDTH-1:0] a,
        input int unsigned            abits
    );
        logic [FETCH_WIDTH-1:0] hi;
        hi = a >> (abits + 2);
        return (a[1:0] != 2'b00) || (hi != '0);
    endfunction

endpackage

// File: rtl/instr_fetch_responder_if.sv
// Fetch request/response handshake bundle.
// master: PC side (drives req, takes resp); slave: the responder.
interface instr_fetch_responder_if
    import rv_fetch_pkg::*;
#(
    parameter int WIDTH = FETCH_WIDTH
) ();

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_addr;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_instr;
    logic [WIDTH-1:0] resp_addr;
    logic             resp_fault;

    modport master (
        output req_valid,
        output req_addr,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_instr,
        input  resp_addr,
        input  resp_fault
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_instr,
        output resp_addr,
        output resp_fault
    );

endinterface

// File: rtl/instr_fetch_responder_fifo.sv
// Response buffer: FWFT FIFO of fetch_resp_t with synchronous flush.
// Ports: push_i/data_i in, pop_i/data_o/empty_o out; data_o is 0 when empty.
module fetch_resp_fifo
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        push_i,
    input  fetch_resp_t data_i,
    input  logic        pop_i,
    output fetch_resp_t data_o,
    output logic        empty_o
);

    localparam int PW = $clog2(DEPTH);

    fetch_resp_t     mem_q [DEPTH];
    logic [PW-1:0]   wr_q;
    logic [PW-1:0]   rd_q;
    logic [PW:0]     cnt_q;
    logic [PW:0]     cnt_d;
    logic            do_pop;

    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;

    // Upstream counts in-flight entries, so a push never meets a full buffer.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({push_i, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    assign data_o = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/instr_fetch_responder.sv
// Instruction memory responder: in-order fetch responses after LATENCY.
// Ports: clk/rst, flush, bus (req/resp handshake), load_* write port, outstanding.
module instr_fetch_responder
    import rv_fetch_pkg::*;
#(
    parameter int WIDTH     = FETCH_WIDTH,
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2,
    parameter int Q_DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    instr_fetch_responder_if.slave     bus,
    input  logic                       load_en,
    input  logic [ADDR_BITS-1:0]       load_addr,
    input  logic [31:0]                load_data,
    output logic [$clog2(Q_DEPTH):0]   outstanding
);

    localparam int CW = $clog2(Q_DEPTH) + 1;

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_lat
        $error("LATENCY must be 1..4");
    end
    if (Q_DEPTH < LATENCY) begin : g_bad_depth
        $error("Q_DEPTH must be >= LATENCY");
    end

    logic [31:0]          mem [2**ADDR_BITS];
    logic [31:0]          rdata_q;
    logic [LATENCY-1:0]   vld_q;
    logic [WIDTH-1:0]     s0_addr_q;
    logic                 s0_fault_q;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic                 accept;
    logic                 pop;
    logic                 req_fault;
    logic [ADDR_BITS-1:0] req_idx;
    logic                 push;
    logic                 fifo_empty;
    fetch_resp_t          s0_resp;
    fetch_resp_t          tail;
    fetch_resp_t          head;

    assign req_idx   = bus.req_addr[ADDR_BITS+1:2];
    assign req_fault = addr_fault(bus.req_addr, ADDR_BITS);

    // Full is judged on the registered count only: a same-cycle pop
    // does not open a slot until the next cycle.
    assign bus.req_ready = !rst && !flush && !load_en
                         && (cnt_q < CW'(Q_DEPTH));

    assign accept = bus.req_valid && bus.req_ready;
    assign pop    = bus.resp_valid && bus.resp_ready;

    // Read-before-write; faulting fetches leave the array untouched.
    always_ff @(posedge clk) begin
        if (!rst && load_en) begin
            mem[load_addr] <= load_data;
        end
        if (accept && !req_fault) begin
            rdata_q <= mem[req_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s0_addr_q  <= bus.req_addr;
            s0_fault_q <= req_fault;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    always_comb begin
        s0_resp       = '0;
        s0_resp.instr = s0_fault_q ? NOP_INSTR : rdata_q;
        s0_resp.addr  = s0_addr_q;
        s0_resp.fault = s0_fault_q;
    end

    // Stage 0 is the RAM read itself; the rest of LATENCY is padding.
    if (LATENCY == 1) begin : g_nopad
        assign tail = s0_resp;
    end else begin : g_pad
        fetch_resp_t pad_q [LATENCY-1];
        always_ff @(posedge clk) begin
            pad_q[0] <= s0_resp;
            for (int i = 1; i < LATENCY - 1; i++) begin
                pad_q[i] <= pad_q[i-1];
            end
        end
        assign tail = pad_q[LATENCY-2];
    end

    assign push = vld_q[LATENCY-1] && !flush;

    fetch_resp_fifo #(
        .DEPTH (Q_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (push),
        .data_i  (tail),
        .pop_i   (pop),
        .data_o  (head),
        .empty_o (fifo_empty)
    );

    assign bus.resp_valid = !fifo_empty;
    assign bus.resp_instr = head.instr;
    assign bus.resp_addr  = head.addr;
    assign bus.resp_fault = head.fault;

    // Counts pipeline plus buffer, which is what keeps the FIFO from
    // overflowing without a full check on the push side.
    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else begin
            unique case ({accept, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign outstanding = cnt_q;

endmodule
